// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_IDX  = 9;

  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Double-flop synchroniser for the serial line plus a third flop for
// falling-edge (start bit) detection. All flops idle high.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic uart_rxd,
  output logic rx_sync,
  output logic start_edge
);

  logic r_rx_s1;
  logic r_rx_s2;
  logic r_rx_s3;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rxd;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign rx_sync    = r_rx_s2;
  assign start_edge = r_rx_s3 & ~r_rx_s2;

endmodule

// File: rtl/uart_recv_core.sv
// 8N1 UART byte receiver with a one-cycle uart_done strobe.
// Define UART_RECV_FRAME_ERR_EN to check the stop bit and add a frame_err output.
module uart_recv_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic       uart_done,
`ifdef UART_RECV_FRAME_ERR_EN
  output logic       frame_err,
`endif
  output logic [7:0] uart_data
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int CNT_W   = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_CNT / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       IDX_STOP = 4'(STOP_IDX);

  logic w_rx_sync;
  logic w_start_edge;

  uart_state_e          r_state,   w_state_next;
  logic [CNT_W-1:0]     r_clk_cnt, w_clk_cnt_next;
  logic [3:0]           r_bit_idx, w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift,   w_shift_next;
  logic [DATA_BITS-1:0] r_data,    w_data_next;
  logic                 r_done,    w_done_next;
`ifdef UART_RECV_FRAME_ERR_EN
  logic                 r_frame_err, w_frame_err_next;
`endif

  uart_rx_sync u_sync (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .uart_rxd   (uart_rxd),
    .rx_sync    (w_rx_sync),
    .start_edge (w_start_edge)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
`ifdef UART_RECV_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_done    <= w_done_next;
`ifdef UART_RECV_FRAME_ERR_EN
      r_frame_err <= w_frame_err_next;
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_data_next    = r_data;
    w_done_next    = 1'b0;
`ifdef UART_RECV_FRAME_ERR_EN
    w_frame_err_next = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_state_next   = RECV;
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
        end
      end
      RECV: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = r_bit_idx + 4'd1;
        end else begin
          w_clk_cnt_next = r_clk_cnt + CNT_ONE;
        end
        if (r_clk_cnt == CNT_MID) begin
          if (r_bit_idx == 4'd0) begin
            // Line back high at mid start bit: treat as noise.
            if (w_rx_sync) begin
              w_state_next   = IDLE;
              w_clk_cnt_next = '0;
              w_bit_idx_next = '0;
            end
          end else if (r_bit_idx == IDX_STOP) begin
            // Leave mid-stop-bit so an immediately following start edge is seen.
            w_state_next   = IDLE;
            w_clk_cnt_next = '0;
            w_bit_idx_next = '0;
`ifdef UART_RECV_FRAME_ERR_EN
            if (w_rx_sync) begin
              w_data_next = r_shift;
              w_done_next = 1'b1;
            end else begin
              w_frame_err_next = 1'b1;
            end
`else
            w_data_next = r_shift;
            w_done_next = 1'b1;
`endif
          end else begin
            // LSB arrives first, so shifting right lands it in bit 0 after 8 bits.
            w_shift_next = {w_rx_sync, r_shift[DATA_BITS-1:1]};
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign uart_done = r_done;
  assign uart_data = r_data;
`ifdef UART_RECV_FRAME_ERR_EN
  assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_uart_recv_core.sv
// Directed + randomized bench for uart_recv_core; the reference model is the
// list of bytes framed on the line (kept only when the stop bit is accepted).
module tb_uart_recv_core;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
  localparam int LAT      = 9 * BPS + BPS / 2 + 3;
`ifdef UART_RECV_FRAME_ERR_EN
  localparam bit FERR_EN = 1'b1;
`else
  localparam bit FERR_EN = 1'b0;
`endif

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_done;
  logic [7:0] uart_data;
`ifdef UART_RECV_FRAME_ERR_EN
  logic       frame_err;
`endif

  uart_recv_core #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rxd  (uart_rxd),
    .uart_done (uart_done),
`ifdef UART_RECV_FRAME_ERR_EN
    .frame_err (frame_err),
`endif
    .uart_data (uart_data)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Observed strobes
  logic [7:0] q_data[$];
  int         q_time[$];
  int         n_consec  = 0;
  int         n_ferr    = 0;
  logic       prev_done = 1'b0;

  // Reference model: bytes that should be delivered and their start-edge cycles
  logic [7:0] q_exp[$];
  int         q_t0[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always @(negedge sys_clk) begin
    if (uart_done) begin
      q_data.push_back(uart_data);
      q_time.push_back(cyc);
      if (prev_done) n_consec <= n_consec + 1;
    end
    prev_done <= uart_done;
`ifdef UART_RECV_FRAME_ERR_EN
    if (frame_err) n_ferr <= n_ferr + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat);
    n_checks++;
    assert (lat >= LAT - 1 && lat <= LAT + 1) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed latency %0d expected %0d +/-1", tag, lat, LAT);
    end
  endtask

  // Caller must be at a negedge; the frame ends exactly at a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (stop || !FERR_EN) begin
      q_exp.push_back(b);
      q_t0.push_back(cyc);
    end
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      repeat (BPS) @(negedge sys_clk);
    end
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, q_data.size(), q_exp.size());
    for (int i = 0; i < q_exp.size(); i++) begin
      if (i < q_data.size()) begin
        $display("frame %s[%0d]: got 0x%02h want 0x%02h latency %0d", tag, i,
                 q_data[i], q_exp[i], q_time[i] - q_t0[i]);
        check({tag, "_data"}, q_data[i], q_exp[i]);
        check_lat({tag, "_latency"}, q_time[i] - q_t0[i]);
      end
    end
    q_data.delete();
    q_time.delete();
    q_exp.delete();
    q_t0.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         gap;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("reset_done", uart_done, 1'b0);
    check("reset_data", uart_data, 8'h00);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    // Single frame, data held afterwards
    send_frame(8'h12, 1'b1);
    drain("f12");
    repeat (30) @(negedge sys_clk);
    check("hold_12", uart_data, 8'h12);

    // Back-to-back frames with zero idle time
    send_frame(8'h31, 1'b1);
    send_frame(8'h30, 1'b1);
    repeat (5) @(negedge sys_clk);
    check("b2b_spacing", (q_time.size() >= 2) ? q_time[1] - q_time[0] : -1, 10 * BPS);
    drain("b2b");

    // Short low glitch on the idle line
    uart_rxd = 1'b0;
    repeat (3) @(negedge sys_clk);
    uart_rxd = 1'b1;
    repeat (200) @(negedge sys_clk);
    check("glitch_no_done", q_data.size(), 0);
    check("glitch_data", uart_data, 8'h30);

    // Reset during bit 4 of 0xA5
    b = 8'hA5;
    uart_rxd = 1'b0;
    repeat (BPS) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      repeat (BPS) @(negedge sys_clk);
    end
    repeat (4) @(negedge sys_clk);
    sys_rst  = 1'b1;
    uart_rxd = 1'b1;
    #1;
    check("midrst_done", uart_done, 1'b0);
    check("midrst_data", uart_data, 8'h00);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (120) @(negedge sys_clk);
    check("midrst_no_done", q_data.size(), 0);
    send_frame(8'h0F, 1'b1);
    drain("f0F");

    // Stop bit sampled low
    n_ferr = 0;
    send_frame(8'h55, 1'b0);
    uart_rxd = 1'b1;
    repeat (20) @(negedge sys_clk);
    drain("bad_stop");
    check("bad_stop_data", uart_data, FERR_EN ? 8'h0F : 8'h55);
`ifdef UART_RECV_FRAME_ERR_EN
    check("frame_err_pulses", n_ferr, 1);
`endif

    // Extreme data patterns
    send_frame(8'h00, 1'b1);
    repeat (3) @(negedge sys_clk);
    send_frame(8'hFF, 1'b1);
    drain("extremes");

    // Randomized frames with random idle gaps
    for (int k = 0; k < 8; k++) begin
      b   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 15);
      repeat (gap) @(negedge sys_clk);
      send_frame(b, 1'b1);
    end
    repeat (20) @(negedge sys_clk);
    drain("rand");
    check("rand_last_hold", uart_data, b);

    check("done_single_cycle", n_consec, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
